dm_trigger_top: RTL and testbench
=================================

// Module: dm_trigger_top
// PURPOSE
//  Dark-matter detector trigger front end. Watches four 16-bit transceiver sample streams (B0..B3) for a sample above threshold.
//  On a trigger it allocates one of eight BRAM capture buffers and holds it busy until DRAM read-back frees it.
//  triggering_status reports that at least one buffer holds an unread trigger. Top level of the DM capture path.
// PARAMETERS
//  THRESHOLD   20   trigger when sample > THRESHOLD (unsigned 16-bit compare)
//  NUM_CH      4    number of sample channels (fixed by ports; constant only)
//  NUM_BANK    8    number of BRAM capture banks (width of BRAM_ready_mask)
// PORTS
//  clk                  in   1   system clock, all logic on rising edge
//  rst                  in   1   synchronous, active-high reset
//  rx_parallel_data_B0  in   16  channel 0 sample, unsigned
//  rx_parallel_data_B1  in   16  channel 1 sample, unsigned
//  rx_parallel_data_B2  in   16  channel 2 sample, unsigned
//  rx_parallel_data_B3  in   16  channel 3 sample, unsigned
//  BRAM_ready_mask      in   8   bit i=1: bank i is able to accept a capture
//  DRAM_Read_Valid      in   1   one-cycle pulse: oldest busy bank has been read out to DRAM
//  triggering_status    out  1   1 while any bank is busy (unread trigger pending)
// BEHAVIOUR
//  - One clock and one reset. Reset is synchronous, active-high, on rst.
//  - Reset (rst=1 at an edge):
//      - Clears the sample regs, above-threshold flags, busy_mask, alloc order FIFO and trigger counter.
//      - triggering_status=0 the cycle after.
//      - Reset mid-operation discards all pending triggers.
//  - Stage 1 (edge k): register all four samples, BRAM_ready_mask and DRAM_Read_Valid.
//  - Stage 2 (edge k+1), per channel:
//      - above[c] = sample_r[c] > THRESHOLD.
//      - rise[c] = above[c] & ~above_d[c], where above_d is above from the previous cycle.
//      - Triggering is edge-based: a sample held high produces exactly one trigger.
//  - trig = |rise. Only one trigger per cycle, even when several channels rise together.
//  - Allocation on trig:
//      - free = ready_r & ~busy_mask.
//      - Set the lowest-index set bit of free in busy_mask and push its index into a 8-deep order FIFO.
//      - If free==0, drop the trigger. State is unchanged except drop_cnt (8-bit, saturating, internal).
//  - Release when read_r=1 and busy_mask!=0:
//      - Pop the oldest index from the FIFO and clear that busy bit.
//      - read_r with busy_mask==0 is ignored.
//  - Simultaneous alloc+release in the same cycle: both take effect.
//      - Release pops the old head.
//      - Alloc chooses from free computed before release, so a bank never frees and re-allocates in one cycle.
//  - triggering_status = |busy_mask, registered.
//      - A sample above THRESHOLD presented before edge k shows as status=1 after edge k+1 (2-cycle latency).
//  - A bank whose ready bit later drops stays busy until released.
//  - FIFO cannot overflow: the FIFO depth equals NUM_BANK.
// STRUCTURE
//  - Shared package dm_trigger_pkg holds: NUM_CH, NUM_BANK, SAMPLE_W=16, BANK_IDX_W=3, a sample_t typedef, and the lowest-set-bit function.
//  - One sub-module, dm_bank_alloc: busy_mask, order FIFO, priority encoder and drop counter.
//  - The top holds the input regs, comparators and rise detect.
// TESTING
//  1. Reset values:
//     - Stimulus: rst=1 for 3 cycles, B0..B3=16,17,18,19, mask=0.
//     - Required: status=0 and remains 0 after rst=0.
//  2. Single trigger:
//     - Stimulus: mask=8'h01; B0=21 for one cycle, read pulse concurrent with the sample.
//     - Required: status=1 two edges later; the early read is ignored; bank0 stays busy.
//  3. Held sample:
//     - Stimulus: B2=100 for 10 cycles, mask=8'h03.
//     - Required: only bank0 busy (one trigger); after one DRAM_Read_Valid pulse, status=0.
//  4. No free bank:
//     - Stimulus: mask=0; B1 pulses to 50.
//     - Required: status stays 0; drop_cnt=1.
//  5. FIFO order:
//     - Stimulus: mask=8'hFF; three separated B3 pulses to 30; then three read pulses.
//     - Required: banks 0,1,2 are allocated, then freed in order 0,1,2; status falls after the 3rd read.
//  6. Boundary and reset:
//     - Stimulus: sample exactly 20, then sample 65535; assert rst while status=1.
//     - Required: 20 does not trigger; 65535 triggers; reset clears status next cycle.

Source files
------------

// File: rtl/dm_trigger_pkg.sv
// Shared definitions for the dark-matter trigger capture path.
// Holds channel/bank counts, sample width, bank index width, the sample
// type and the lowest-set-bit priority helper used for bank allocation.
package dm_trigger_pkg;

  localparam int NUM_CH     = 4;
  localparam int NUM_BANK   = 8;
  localparam int SAMPLE_W   = 16;
  localparam int BANK_IDX_W = 3;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Index of the lowest set bit of vec; returns 0 when vec is all zero,
  // so callers must qualify the result with |vec.
  function automatic logic [BANK_IDX_W-1:0] lowest_set_idx(input logic [NUM_BANK-1:0] vec);
    logic [BANK_IDX_W-1:0] idx;
    idx = {BANK_IDX_W{1'b0}};
    // Scan downward so the lowest set index is the last one written.
    for (int i = NUM_BANK - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = BANK_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dm_bank_alloc.sv
// Capture-bank allocator.
// Tracks which BRAM banks hold an unread trigger (busy mask), remembers the
// order in which banks were allocated so DRAM read-back frees the oldest one
// first, and counts triggers dropped for lack of a free bank.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   trig                one trigger request this cycle
//   ready_mask[7:0]     bit i=1: bank i can accept a capture
//   read_valid          oldest busy bank has been read out
//   triggering_status   registered |busy_mask
module dm_bank_alloc
  import dm_trigger_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                trig,
  input  logic [NUM_BANK-1:0] ready_mask,
  input  logic                read_valid,
  output logic                triggering_status
);

  localparam logic [NUM_BANK-1:0] ONE_HOT0 = {{(NUM_BANK-1){1'b0}}, 1'b1};

  logic [NUM_BANK-1:0]   busy_q, busy_d;
  logic [BANK_IDX_W-1:0] order_q [NUM_BANK];
  logic [BANK_IDX_W-1:0] order_d [NUM_BANK];
  logic [BANK_IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [BANK_IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic                  status_q, status_d;

  logic [NUM_BANK-1:0]   free_s;
  logic                  alloc_s;
  logic                  drop_s;
  logic                  rel_s;
  logic [BANK_IDX_W-1:0] alloc_idx_s;
  logic [BANK_IDX_W-1:0] rel_idx_s;

  // Next-state for busy mask, order FIFO, drop counter and status.
  always_comb begin
    // free is taken from the pre-release mask so a bank cannot free and
    // re-allocate in the same cycle.
    free_s      = ready_mask & ~busy_q;
    alloc_s     = trig & (|free_s);
    drop_s      = trig & ~(|free_s);
    // The FIFO is empty exactly when no bank is busy, so busy_q doubles as
    // the non-empty flag.
    rel_s       = read_valid & (|busy_q);
    alloc_idx_s = lowest_set_idx(free_s);
    rel_idx_s   = order_q[rd_ptr_q];

    busy_d     = busy_q;
    order_d    = order_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;

    if (rel_s) begin
      busy_d   = busy_d & ~(ONE_HOT0 << rel_idx_s);
      rd_ptr_d = rd_ptr_q + 3'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Depth equals bank count, so a push can never overflow.
    if (alloc_s) begin
      busy_d            = busy_d | (ONE_HOT0 << alloc_idx_s);
      order_d[wr_ptr_q] = alloc_idx_s;
      wr_ptr_d          = wr_ptr_q + 3'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    status_d = |busy_d;
  end

  // Allocator state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= {NUM_BANK{1'b0}};
      wr_ptr_q   <= {BANK_IDX_W{1'b0}};
      rd_ptr_q   <= {BANK_IDX_W{1'b0}};
      drop_cnt_q <= 8'd0;
      status_q   <= 1'b0;
      for (int i = 0; i < NUM_BANK; i++) begin
        order_q[i] <= {BANK_IDX_W{1'b0}};
      end
    end else begin
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      status_q   <= status_d;
      order_q    <= order_d;
    end
  end

  assign triggering_status = status_q;

endmodule

// File: rtl/dm_trigger_top.sv
// Dark-matter detector trigger front end.
// Registers four 16-bit sample streams plus bank-ready mask and DRAM read
// pulse, detects a rising edge of "sample > THRESHOLD" on any channel and
// hands one trigger per cycle to the bank allocator.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rx_parallel_data_B0..B3      unsigned channel samples
//   BRAM_ready_mask[7:0]         bit i=1: bank i can accept a capture
//   DRAM_Read_Valid              pulse: oldest busy bank read out
//   triggering_status            1 while any bank holds an unread trigger
module dm_trigger_top
  import dm_trigger_pkg::*;
#(
  parameter sample_t THRESHOLD = 16'd20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         rx_parallel_data_B0,
  input  logic [15:0]         rx_parallel_data_B1,
  input  logic [15:0]         rx_parallel_data_B2,
  input  logic [15:0]         rx_parallel_data_B3,
  input  logic [NUM_BANK-1:0] BRAM_ready_mask,
  input  logic                DRAM_Read_Valid,
  output logic                triggering_status
);

  sample_t [NUM_CH-1:0] sample_q, sample_d;
  logic [NUM_BANK-1:0]  ready_q, ready_d;
  logic                 read_q, read_d;
  logic [NUM_CH-1:0]    above_q, above_d;

  logic [NUM_CH-1:0]    above_s;
  logic [NUM_CH-1:0]    rise_s;
  logic                 trig_s;

  // Input capture and per-channel threshold / rising-edge detect.
  always_comb begin
    sample_d[0] = rx_parallel_data_B0;
    sample_d[1] = rx_parallel_data_B1;
    sample_d[2] = rx_parallel_data_B2;
    sample_d[3] = rx_parallel_data_B3;
    ready_d     = BRAM_ready_mask;
    read_d      = DRAM_Read_Valid;

    for (int c = 0; c < NUM_CH; c++) begin
      above_s[c] = sample_q[c] > THRESHOLD;
    end
    // Edge-based: a sample held above threshold triggers only once.
    rise_s  = above_s & ~above_q;
    // Several channels rising together still make a single trigger.
    trig_s  = |rise_s;
    above_d = above_s;
  end

  // Stage-1 input registers and the previous-cycle above flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= {(NUM_CH*SAMPLE_W){1'b0}};
      ready_q  <= {NUM_BANK{1'b0}};
      read_q   <= 1'b0;
      above_q  <= {NUM_CH{1'b0}};
    end else begin
      sample_q <= sample_d;
      ready_q  <= ready_d;
      read_q   <= read_d;
      above_q  <= above_d;
    end
  end

  dm_bank_alloc u_alloc (
    .clk               (clk),
    .rst               (rst),
    .trig              (trig_s),
    .ready_mask        (ready_q),
    .read_valid        (read_q),
    .triggering_status (triggering_status)
  );

endmodule

// File: tb/tb_dm_trigger_top.sv
module tb_dm_trigger_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] b0, b1, b2, b3;
  logic [7:0]  mask;
  logic        rd;
  logic        status;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dm_trigger_top dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_parallel_data_B0 (b0),
    .rx_parallel_data_B1 (b1),
    .rx_parallel_data_B2 (b2),
    .rx_parallel_data_B3 (b3),
    .BRAM_ready_mask     (mask),
    .DRAM_Read_Valid     (rd),
    .triggering_status   (status)
  );

  // ---------------- reference model (spec-level, queue based) -------------
  int unsigned m_samp [4];
  bit          m_above_prev [4];
  bit          m_ready [8];
  bit          m_read;
  bit          m_busy [8];
  int          m_order [$];
  int          m_drop;
  bit          m_status;

  function automatic logic [7:0] m_busy_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  function automatic void model_edge();
    bit above [4];
    bit trig;
    int pick;
    if (rst) begin
      for (int c = 0; c < 4; c++) begin m_samp[c] = 0; m_above_prev[c] = 0; end
      for (int i = 0; i < 8; i++) begin m_ready[i] = 0; m_busy[i] = 0; end
      m_read = 0;
      m_order.delete();
      m_drop = 0;
      m_status = 0;
    end else begin
      trig = 0;
      for (int c = 0; c < 4; c++) begin
        above[c] = m_samp[c] > 20;
        if (above[c] && !m_above_prev[c]) trig = 1;
      end
      pick = -1;
      for (int i = 0; i < 8; i++)
        if (pick < 0 && m_ready[i] && !m_busy[i]) pick = i;
      if (m_read && m_order.size() > 0) begin
        int h;
        h = m_order.pop_front();
        m_busy[h] = 0;
      end
      if (trig) begin
        if (pick >= 0) begin
          m_busy[pick] = 1;
          m_order.push_back(pick);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      m_status = (m_busy_vec() != 8'd0);
      for (int c = 0; c < 4; c++) m_above_prev[c] = above[c];
      m_samp[0] = b0; m_samp[1] = b1; m_samp[2] = b2; m_samp[3] = b3;
      for (int i = 0; i < 8; i++) m_ready[i] = mask[i];
      m_read = rd;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: update the model, take the edge, compare away from the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_status", int'(status), int'(m_status));
    chk("model_busy", int'(dut.u_alloc.busy_q), int'(m_busy_vec()));
  endtask

  task automatic drive(input logic r, input logic [15:0] s0, input logic [15:0] s1,
                       input logic [15:0] s2, input logic [15:0] s3,
                       input logic [7:0] m, input logic p);
    rst = r; b0 = s0; b1 = s1; b2 = s2; b3 = s3; mask = m; rd = p;
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic        r;
    logic [15:0] s0, s1, s2, s3;
    logic [7:0]  m;
    logic        p;
    logic        exp_status;
    logic [7:0]  exp_busy;
    string       nm;
  } vec_t;

  vec_t vecs [$];

  function automatic void add(input logic r, input logic [15:0] s0, input logic [15:0] s1,
                              input logic [15:0] s2, input logic [15:0] s3,
                              input logic [7:0] m, input logic p,
                              input logic es, input logic [7:0] eb, input string nm);
    vec_t v;
    v.r = r; v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3; v.m = m; v.p = p;
    v.exp_status = es; v.exp_busy = eb; v.nm = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    drive(1'b1, 16'd16, 16'd17, 16'd18, 16'd19, 8'h00, 1'b0);

    // 1: reset values
    for (int i = 0; i < 3; i++) add(1, 16, 17, 18, 19, 8'h00, 0, 0, 8'h00, "reset");
    for (int i = 0; i < 2; i++) add(0, 16, 17, 18, 19, 8'h00, 0, 0, 8'h00, "post_reset");
    // 2: single trigger, early read ignored
    add(0, 21, 0, 0, 0, 8'h01, 1, 0, 8'h00, "single_stage1");
    add(0,  0, 0, 0, 0, 8'h01, 0, 1, 8'h01, "single_alloc");
    add(0,  0, 0, 0, 0, 8'h01, 0, 1, 8'h01, "single_hold");
    add(0,  0, 0, 0, 0, 8'h01, 1, 1, 8'h01, "single_read_reg");
    add(0,  0, 0, 0, 0, 8'h01, 0, 0, 8'h00, "single_release");
    // 3: held sample produces one trigger
    add(0, 0, 0, 100, 0, 8'h03, 0, 0, 8'h00, "held_stage1");
    for (int i = 0; i < 9; i++) add(0, 0, 0, 100, 0, 8'h03, 0, 1, 8'h01, "held_once");
    add(0, 0, 0, 0, 0, 8'h03, 1, 1, 8'h01, "held_read_reg");
    add(0, 0, 0, 0, 0, 8'h03, 0, 0, 8'h00, "held_release");
    // 4: no free bank
    add(0, 0, 50, 0, 0, 8'h00, 0, 0, 8'h00, "nofree_stage1");
    add(0, 0,  0, 0, 0, 8'h00, 0, 0, 8'h00, "nofree_drop");
    add(0, 0,  0, 0, 0, 8'h00, 0, 0, 8'h00, "nofree_idle");

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].m, vecs[i].p);
      step();
      chk({vecs[i].nm, "_status"}, int'(status), int'(vecs[i].exp_status));
      chk({vecs[i].nm, "_busy"}, int'(dut.u_alloc.busy_q), int'(vecs[i].exp_busy));
    end
    chk("drop_cnt", int'(dut.u_alloc.drop_cnt_q), 1);
    chk("drop_cnt_model", int'(dut.u_alloc.drop_cnt_q), m_drop);

    // 5: FIFO order
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 30, 8'hFF, 0); step();
      drive(0, 0, 0, 0, 0, 8'hFF, 0); step(); step();
    end
    chk("fifo_alloc_busy", int'(dut.u_alloc.busy_q), 32'h07);
    begin
      logic [7:0] exp_after [3];
      exp_after[0] = 8'h06; exp_after[1] = 8'h04; exp_after[2] = 8'h00;
      for (int k = 0; k < 3; k++) begin
        drive(0, 0, 0, 0, 0, 8'hFF, 1); step();
        drive(0, 0, 0, 0, 0, 8'hFF, 0); step();
        chk("fifo_free_order", int'(dut.u_alloc.busy_q), int'(exp_after[k]));
        chk("fifo_status", int'(status), (k == 2) ? 0 : 1);
      end
    end

    // 6: threshold boundary and reset while busy
    drive(0, 20, 0, 0, 0, 8'hFF, 0); step();
    drive(0, 0, 0, 0, 0, 8'hFF, 0); step(); step();
    chk("thresh_eq_no_trig", int'(status), 0);
    drive(0, 16'hFFFF, 0, 0, 0, 8'hFF, 0); step();
    drive(0, 0, 0, 0, 0, 8'hFF, 0); step();
    chk("max_sample_trig", int'(status), 1);
    chk("max_sample_busy", int'(dut.u_alloc.busy_q), 1);
    drive(1, 0, 0, 0, 0, 8'hFF, 0); step();
    chk("reset_clears_status", int'(status), 0);
    drive(0, 0, 0, 0, 0, 8'hFF, 0); step();
    chk("reset_stays_clear", int'(status), 0);
    chk("reset_drop_clear", int'(dut.u_alloc.drop_cnt_q), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [15:0] s [4];
      for (int c = 0; c < 4; c++)
        s[c] = ($urandom_range(7) == 0) ? 16'($urandom_range(65535, 21))
                                        : 16'($urandom_range(20));
      drive(($urandom_range(149) == 0), s[0], s[1], s[2], s[3],
            8'($urandom), ($urandom_range(3) == 0));
      step();
    end
    chk("rand_drop_model", int'(dut.u_alloc.drop_cnt_q), m_drop);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
